// File: rtl/mcu_mem_pkg.sv
// Shared constants and types for the MCU word-SRAM subsystem.
package mcu_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16384;

  // Which requester owns the read data returning from the SRAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/sram_arb_prio.sv
// Grant decision between fetch and data, with a streak limit on data wins.
module sram_arb_prio #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  output logic grant_d,
  output logic grant_i
);

  localparam int unsigned           STREAK_W   = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic                fetch_due;

  // Data wins unless fetch has waited through MAX_STREAK data grants; nothing is granted in reset.
  always_comb begin
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    streak_nxt = streak;
    fetch_due  = (streak == STREAK_MAX);
    if (!rst) begin
      if (d_req && !(if_req && fetch_due)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
    if (!if_req || grant_i) begin
      streak_nxt = '0;
    end else if (grant_d && !fetch_due) begin
      streak_nxt = streak + STREAK_W'(1);
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else begin
      streak <= streak_nxt;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port word SRAM between instruction fetch and load/store.
module sram_arbiter
  import mcu_mem_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  logic              grant_d;
  logic              grant_i;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_read;
  logic              sel_write;
  logic              sel_in_range;
  owner_t            owner;

  sram_arb_prio #(
    .MAX_STREAK (MAX_STREAK)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .d_req   (d_req),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  // Select the granted access and check it against the implemented depth.
  always_comb begin
    sel_addr  = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    if (grant_d) begin
      sel_addr  = d_addr;
      sel_read  = !d_we;
      sel_write = d_we;
    end else if (grant_i) begin
      sel_addr  = if_addr;
      sel_read  = 1'b1;
    end
    sel_in_range = (32'(sel_addr) < DEPTH);
  end

  assign if_gnt       = grant_i;
  assign d_gnt        = grant_d;
  assign sram_address = sel_addr;
  assign sram_rd_en   = sel_read & sel_in_range;
  assign sram_wr_en   = sel_write & sel_in_range;
  assign sram_data_in = sel_write ? d_wdata : '0;

  // Remember who owns next cycle's read data and which responses are due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      owner     <= sram_rd_en ? (grant_i ? OWN_IF : OWN_D) : OWN_NONE;
      if_rvalid <= grant_i;
      if_err    <= grant_i & !sel_in_range;
      d_rvalid  <= grant_d & (!d_we | !sel_in_range);
      d_err     <= grant_d & !sel_in_range;
    end
  end

  // SRAM data goes only to its owner; everyone else sees zero.
  assign if_rdata = (owner == OWN_IF) ? sram_data_out : '0;
  assign d_rdata  = (owner == OWN_D)  ? sram_data_out : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, reference model, directed and random stimulus.
module tb_sram_arbiter;
  import mcu_mem_pkg::*;

  localparam int unsigned MAX_STREAK = 4;
  localparam int unsigned IDX_W      = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              sram_rd_en, sram_wr_en;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_data_in;
  logic [DATA_W-1:0] sram_data_out = '0;

  int total = 0;
  int bad   = 0;

  sram_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int unsigned a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural single-port SRAM, 1-cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_address[IDX_W-1:0]] = sram_data_in;
    if (sram_rd_en) sram_data_out <= mem[sram_address[IDX_W-1:0]];
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                streak_m = 0, streak_nx = 0;
  logic              p_if_v = 0, p_if_e = 0, p_d_v = 0, p_d_e = 0;
  logic [DATA_W-1:0] p_if_d = '0, p_d_d = '0;
  logic              n_if_v = 0, n_if_e = 0, n_d_v = 0, n_d_e = 0;
  logic [DATA_W-1:0] n_if_d = '0, n_d_d = '0;
  logic              n_wr = 0;
  logic [ADDR_W-1:0] n_wa = '0;
  logic [DATA_W-1:0] n_wd = '0;
  logic              e_gd, e_gi, e_inr, e_rd, e_wr;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_din;

  // Compare every output against the model each cycle, then plan the next model state.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_if_gnt", 32'(if_gnt), 0);       chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0); chk("rst_if_err", 32'(if_err), 0);
      chk("rst_d_rvalid", 32'(d_rvalid), 0);   chk("rst_d_err", 32'(d_err), 0);
      chk("rst_if_rdata", if_rdata, 0);        chk("rst_d_rdata", d_rdata, 0);
      chk("rst_rd_en", 32'(sram_rd_en), 0);    chk("rst_wr_en", 32'(sram_wr_en), 0);
      chk("rst_addr", 32'(sram_address), 0);   chk("rst_din", sram_data_in, 0);
      n_wr = 0; n_if_v = 0; n_if_e = 0; n_if_d = '0; n_d_v = 0; n_d_e = 0; n_d_d = '0;
      streak_nx = 0;
    end else begin
      e_gd = d_req && !(if_req && streak_m == int'(MAX_STREAK));
      e_gi = if_req && !e_gd;
      e_addr = e_gd ? d_addr : (e_gi ? if_addr : '0);
      e_inr  = int'(e_addr) < int'(DEPTH);
      e_rd   = ((e_gd && !d_we) || e_gi) && e_inr;
      e_wr   = e_gd && d_we && e_inr;
      e_din  = (e_gd && d_we) ? d_wdata : '0;
      chk("if_gnt", 32'(if_gnt), 32'(e_gi));    chk("d_gnt", 32'(d_gnt), 32'(e_gd));
      chk("rd_en", 32'(sram_rd_en), 32'(e_rd)); chk("wr_en", 32'(sram_wr_en), 32'(e_wr));
      chk("addr", 32'(sram_address), 32'(e_addr)); chk("din", sram_data_in, e_din);
      chk("if_rvalid", 32'(if_rvalid), 32'(p_if_v)); chk("if_err", 32'(if_err), 32'(p_if_e));
      chk("if_rdata", if_rdata, p_if_d);
      chk("d_rvalid", 32'(d_rvalid), 32'(p_d_v));    chk("d_err", 32'(d_err), 32'(p_d_e));
      chk("d_rdata", d_rdata, p_d_d);
      n_if_v = e_gi; n_if_e = e_gi && !e_inr;
      n_if_d = (e_gi && e_inr) ? ref_mem[e_addr[IDX_W-1:0]] : '0;
      n_d_v  = e_gd && (!d_we || !e_inr); n_d_e = e_gd && !e_inr;
      n_d_d  = (e_gd && !d_we && e_inr) ? ref_mem[e_addr[IDX_W-1:0]] : '0;
      n_wr = e_wr; n_wa = e_addr; n_wd = d_wdata;
      if (!if_req || e_gi) streak_nx = 0;
      else if (e_gd) streak_nx = (streak_m + 1 > int'(MAX_STREAK)) ? int'(MAX_STREAK) : streak_m + 1;
      else streak_nx = streak_m;
    end
  end

  // Commit the planned model state at the clock edge; reset discards it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_if_v <= 0; p_if_e <= 0; p_if_d <= '0; p_d_v <= 0; p_d_e <= 0; p_d_d <= '0;
      streak_m <= 0;
    end else begin
      p_if_v <= n_if_v; p_if_e <= n_if_e; p_if_d <= n_if_d;
      p_d_v <= n_d_v; p_d_e <= n_d_e; p_d_d <= n_d_d;
      streak_m <= streak_nx;
      if (n_wr) ref_mem[n_wa[IDX_W-1:0]] = n_wd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic req, input logic [ADDR_W-1:0] a);
    if_req = req; if_addr = a;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int unsigned r = $urandom_range(0, 99);
    if (r < 70) return ADDR_W'($urandom_range(0, 31));
    else if (r < 85) return ADDR_W'($urandom_range(DEPTH - 2, DEPTH + 1));
    else return ADDR_W'($urandom);
  endfunction

  bit   t3_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic hold_if;

  initial begin
    rst = 1'b1;
    set_if(0, '0);
    set_d(0, 0, '0, '0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = init_val(i); ref_mem[i] = init_val(i);
    end
    mem[16'h0010] = 32'hE3A00001; ref_mem[16'h0010] = 32'hE3A00001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_if_rvalid", 32'(if_rvalid), 0);
    step(); rst = 1'b0;

    // 1: fetch read of preloaded word
    step(); set_if(1, 16'h0010);
    @(negedge clk); chk("t1_if_gnt", 32'(if_gnt), 1); chk("t1_rd_en", 32'(sram_rd_en), 1);
    step(); set_if(0, '0);
    @(negedge clk); chk("t1_if_rvalid", 32'(if_rvalid), 1);
    chk("t1_if_rdata", if_rdata, 32'hE3A00001); chk("t1_d_rvalid", 32'(d_rvalid), 0);

    // 2: data write then fetch read of same word next cycle
    step(); set_d(1, 1, 16'h0020, 32'hDEADBEEF);
    @(negedge clk); chk("t2_wr_en", 32'(sram_wr_en), 1);
    step(); set_d(0, 0, '0, '0); set_if(1, 16'h0020);
    @(negedge clk); chk("t2_if_gnt", 32'(if_gnt), 1);
    step(); set_if(0, '0);
    @(negedge clk); chk("t2_if_rdata", if_rdata, 32'hDEADBEEF);

    // 3: both requesting reads for 10 cycles
    step(); set_if(1, 16'h0005); set_d(1, 0, 16'h0006, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_d_gnt", 32'(d_gnt), 32'(t3_seq[k]));
      chk("t3_if_gnt", 32'(if_gnt), 32'(!t3_seq[k]));
      if (k > 0) chk("t3_d_rvalid", 32'(d_rvalid), 32'(t3_seq[k-1]));
      step();
    end
    set_if(0, '0); set_d(0, 0, '0, '0);

    // 4: out-of-range data read and write
    step(); set_d(1, 0, 16'h4000, '0);
    @(negedge clk); chk("t4_d_gnt", 32'(d_gnt), 1); chk("t4_rd_en", 32'(sram_rd_en), 0);
    step(); set_d(1, 1, 16'h4000, 32'h12345678);
    @(negedge clk); chk("t4_d_rvalid", 32'(d_rvalid), 1); chk("t4_d_err", 32'(d_err), 1);
    chk("t4_d_rdata", d_rdata, 0); chk("t4_wr_en", 32'(sram_wr_en), 0);
    step(); set_d(0, 0, '0, '0);
    @(negedge clk); chk("t4_wr_d_rvalid", 32'(d_rvalid), 1); chk("t4_wr_d_err", 32'(d_err), 1);

    // 5: async reset during a granted read cycle
    step(); set_if(1, 16'h0003);
    @(negedge clk); chk("t5_if_gnt", 32'(if_gnt), 1);
    #1 rst = 1'b1;
    #1 chk("t5_gnt_in_rst", 32'(if_gnt), 0); chk("t5_rd_en_in_rst", 32'(sram_rd_en), 0);
    step(); chk("t5_no_rvalid", 32'(if_rvalid), 0);
    step(); rst = 1'b0; set_if(1, 16'h0004);
    @(negedge clk); chk("t5_gnt_after", 32'(if_gnt), 1); chk("t5_no_rvalid2", 32'(if_rvalid), 0);
    step(); set_if(0, '0);
    @(negedge clk); chk("t5_rdata_after", if_rdata, init_val(4));

    // 6: alternating fetch / data reads
    for (int k = 0; k < 20; k++) begin
      step();
      if (k % 2 == 0) begin set_if(1, 16'h0001); set_d(0, 0, '0, '0); end
      else begin set_if(0, '0); set_d(1, 0, 16'h0002, '0); end
      @(negedge clk);
      chk("t6_one_gnt", 32'(if_gnt | d_gnt), 1);
      if (k > 0 && k % 2 == 1) chk("t6_if_rdata", if_rdata, init_val(1));
      if (k > 0 && k % 2 == 0) chk("t6_d_rdata", d_rdata, init_val(2));
    end

    // Random traffic checked by the model
    hold_if = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!hold_if) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = rand_addr();
      end
      d_req = ($urandom_range(0, 99) < 50);
      d_we  = ($urandom_range(0, 99) < 35);
      d_addr = rand_addr();
      d_wdata = $urandom;
      @(negedge clk);
      hold_if = if_req && !if_gnt;
      if (i == 1000) begin
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        hold_if = 1'b0;
      end
    end
    step(); set_if(0, '0); set_d(0, 0, '0, '0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
